// File: rtl/branch_arbiter.sv
// ============================================================================
//  Module   : branch_arbiter
//  Purpose  : Two-requester fair arbiter that supplies the branch decision to a
//             sequence engine, with a stall timeout and optional hit statistics
//             (enabled by macro BRANCH_ARBITER_HIT_STATS_EN).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module branch_arbiter #(
    parameter int         TO_LIMIT  = 15,
    parameter logic [3:0] HIT_STATE = 4'd9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] st,
    input  logic       req0,
    input  logic       req1,
    input  logic       dec0,
    input  logic       dec1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       i1,
    output logic       hit,
    output logic [7:0] hit_cnt,
    output logic       timeout
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GNT0  = 2'd1,
        S_GNT1  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    localparam logic [4:0] c_to_limit = 5'(TO_LIMIT);

    state_t     state_q, state_d;
    logic       i1_q, i1_d;
    logic       last_q, last_d;      // 1: requester 1 was granted most recently
    logic [3:0] stall_q, stall_d;
    logic       timeout_q, timeout_d;

    logic       w_decision;
    logic [4:0] w_stall_inc;

    assign w_decision  = (st == 4'd2) || (st == 4'd5);
    assign w_stall_inc = {1'b0, stall_q} + 5'd1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            i1_q      <= 1'b0;
            last_q    <= 1'b1;
            stall_q   <= 4'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            i1_q      <= i1_d;
            last_q    <= last_d;
            stall_q   <= stall_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = S_IDLE;
        i1_d      = i1_q;
        last_d    = last_q;
        stall_d   = stall_q;
        timeout_d = timeout_q;

        if (state_q == S_FAULT) begin
            state_d = S_FAULT;
            i1_d    = 1'b0;
        end else if (w_decision) begin
            // Ties go to whichever requester was not served last
            if (req0 && (!req1 || last_q)) begin
                state_d = S_GNT0;
                i1_d    = dec0;
                last_d  = 1'b0;
                stall_d = 4'd0;
            end else if (req1) begin
                state_d = S_GNT1;
                i1_d    = dec1;
                last_d  = 1'b1;
                stall_d = 4'd0;
            end else begin
                i1_d    = 1'b0;
                stall_d = w_stall_inc[3:0];
                if (w_stall_inc >= c_to_limit) begin
                    state_d   = S_FAULT;
                    timeout_d = 1'b1;
                end
            end
        end
    end

    assign gnt0    = (state_q == S_GNT0);
    assign gnt1    = (state_q == S_GNT1);
    assign i1      = i1_q;
    assign timeout = timeout_q;

`ifdef BRANCH_ARBITER_HIT_STATS_EN
    logic       hit_q;
    logic [7:0] hit_cnt_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            hit_q     <= 1'b0;
            hit_cnt_q <= 8'd0;
        end else begin
            hit_q <= (st == HIT_STATE);
            if (hit_q && (hit_cnt_q != 8'hFF)) begin
                hit_cnt_q <= hit_cnt_q + 8'd1;
            end
        end
    end

    assign hit     = hit_q;
    assign hit_cnt = hit_cnt_q;
`else
    logic w_unused_hit;
    assign w_unused_hit = (st == HIT_STATE);
    assign hit          = 1'b0;
    assign hit_cnt      = 8'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_arbiter.sv
// ============================================================================
//  Module   : tb_branch_arbiter
//  Purpose  : Directed self-checking bench for branch_arbiter (TO_LIMIT = 3).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_branch_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] st;
    logic       req0, req1, dec0, dec1;
    logic       gnt0, gnt1, i1, hit, timeout;
    logic [7:0] hit_cnt;

    int n_chk = 0;
    int n_err = 0;

`ifdef BRANCH_ARBITER_HIT_STATS_EN
    localparam bit c_stats = 1'b1;
`else
    localparam bit c_stats = 1'b0;
`endif

    branch_arbiter #(.TO_LIMIT(3), .HIT_STATE(4'd9)) u_dut (
        .clk     (clk),
        .reset   (reset),
        .st      (st),
        .req0    (req0),
        .req1    (req1),
        .dec0    (dec0),
        .dec1    (dec1),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .i1      (i1),
        .hit     (hit),
        .hit_cnt (hit_cnt),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_inputs();
        st = 4'd0; req0 = 1'b0; req1 = 1'b0; dec0 = 1'b0; dec1 = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b0;
        tick(2);
        chk("rst_gnt0", gnt0, 0);
        chk("rst_gnt1", gnt1, 0);
        chk("rst_i1", i1, 0);
        chk("rst_hit", hit, 0);
        chk("rst_hitcnt", hit_cnt, 0);
        chk("rst_timeout", timeout, 0);

        // Single request at a decision point
        reset = 1'b1;
        st = 4'd2; req0 = 1'b1; dec0 = 1'b1;
        tick(1);
        chk("single_gnt0", gnt0, 1);
        chk("single_i1", i1, 1);
        chk("single_gnt1", gnt1, 0);
        idle_inputs();
        tick(1);
        chk("nondec_gnt0", gnt0, 0);
        chk("nondec_i1_hold", i1, 1);

        // Tie-breaking: req0 wins first, then alternation
        do_reset();
        st = 4'd2; req0 = 1'b1; req1 = 1'b1; dec0 = 1'b0; dec1 = 1'b1;
        tick(1);
        chk("tie1_gnt0", gnt0, 1);
        chk("tie1_gnt1", gnt1, 0);
        chk("tie1_i1", i1, 0);
        st = 4'd5;
        tick(1);
        chk("tie2_gnt1", gnt1, 1);
        chk("tie2_gnt0", gnt0, 0);
        chk("tie2_i1", i1, 1);
        tick(1);
        chk("tie3_gnt0", gnt0, 1);
        chk("tie3_i1", i1, 0);

        // Back-to-back grants to the same lone requester
        idle_inputs();
        st = 4'd2; req1 = 1'b1; dec1 = 1'b1;
        tick(1);
        chk("b2b1_gnt1", gnt1, 1);
        st = 4'd5; dec1 = 1'b0;
        tick(1);
        chk("b2b2_gnt1", gnt1, 1);
        chk("b2b2_i1", i1, 0);

        // Request held across non-decision states stays pending
        do_reset();
        req1 = 1'b1; dec1 = 1'b1;
        st = 4'd8;  tick(1); chk("pend_st8", gnt1, 0);
        st = 4'd10; tick(1); chk("pend_st10", gnt1, 0);
        st = 4'd1;  tick(1); chk("pend_st1", gnt1, 0);
        st = 4'd2;  tick(1);
        chk("pend_gnt1", gnt1, 1);
        chk("pend_i1", i1, 1);

        // Reset wins over a grant in the same cycle
        idle_inputs();
        reset = 1'b0; st = 4'd2; req0 = 1'b1; dec0 = 1'b1;
        tick(1);
        chk("rstpri_gnt0", gnt0, 0);
        chk("rstpri_i1", i1, 0);
        reset = 1'b1;
        idle_inputs();

        // A grant clears the stall counter
        do_reset();
        st = 4'd2;
        tick(2);
        req0 = 1'b1;
        tick(1);
        chk("clr_gnt0", gnt0, 1);
        req0 = 1'b0;
        tick(2);
        chk("clr_timeout", timeout, 0);
        chk("clr_i1", i1, 0);

        // Timeout after three starved decision points, sticky until reset
        do_reset();
        st = 4'd2;
        tick(2);
        chk("to_pre", timeout, 0);
        tick(1);
        chk("to_set", timeout, 1);
        st = 4'd5; req0 = 1'b1; dec0 = 1'b1;
        tick(1);
        chk("fault_gnt0", gnt0, 0);
        chk("fault_i1", i1, 0);
        chk("fault_sticky", timeout, 1);
        idle_inputs();
        reset = 1'b0;
        tick(1);
        chk("fault_rst", timeout, 0);
        reset = 1'b1;

        // Hit statistics
        do_reset();
        st = 4'd9;
        tick(1);
        chk("hit_first", hit, c_stats ? 1 : 0);
        chk("hitcnt_first", hit_cnt, 0);
        tick(9);
        chk("hitcnt_10", hit_cnt, c_stats ? 9 : 0);
        tick(290);
        chk("hit_sat", hit, c_stats ? 1 : 0);
        chk("hitcnt_sat", hit_cnt, c_stats ? 255 : 0);
        st = 4'd0;
        tick(1);
        chk("hit_off", hit, 0);
        chk("hitcnt_hold", hit_cnt, c_stats ? 255 : 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/branch_arbiter.md
BRANCH_ARBITER -- requirements
Module: branch_arbiter

Interface
REQ-001 Parameter TO_LIMIT, default 15, SHALL set the number of consecutive unserved decision cycles that trips the timeout (legal range 1..15).
REQ-002 Parameter HIT_STATE, default 4'd9, SHALL set the engine state value counted as a hit.
REQ-003 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  reset; synchronous, active-low.
REQ-005 st  input  4  current state of the sequence engine being controlled.
REQ-006 req0, req1  input  1 each  requester asks to supply the engine's branch decision.
REQ-007 dec0, dec1  input  1 each  decision bit offered by each requester; valid while its req is high.
REQ-008 gnt0, gnt1  output  1 each  one-cycle grant pulse; registered.
REQ-009 i1  output  1  branch decision driven to the engine; registered.
REQ-010 hit  output  1  registered pulse, high the cycle after st equalled HIT_STATE.
REQ-011 hit_cnt  output  8  saturating hit count.
REQ-012 timeout  output  1  sticky fault flag.

Function
REQ-013 A decision point SHALL be any cycle with st==4'd2 or st==4'd5; all other st values are non-decision.
REQ-014 The FSM SHALL have states IDLE, GNT0, GNT1 and FAULT; gnt0 SHALL be 1 only in GNT0, gnt1 only in GNT1.
REQ-015 From IDLE, GNT0 or GNT1, at a decision point with exactly one req high, the next state SHALL be that requester's GNT state, with i1 <= its dec.
REQ-016 With both req high at a decision point, the winner SHALL be the requester not granted last; the last-granted pointer SHALL reset to 1, so req0 wins the first tie.
REQ-017 Grant latency SHALL be one cycle: request sampled at edge N, gnt high during cycle N+1, i1 valid from cycle N+1.
REQ-018 A GNT state SHALL last exactly one cycle, then re-arbitrate on the next edge; back-to-back grants on consecutive decision points (st 2 then 5) SHALL be allowed, including to the same requester when the other is idle.
REQ-019 A requester SHALL hold req and dec stable until it sees gnt; req with no decision point SHALL produce no grant and SHALL stay pending.
REQ-020 At a non-decision point the next state SHALL be IDLE and i1 SHALL hold its value.
REQ-021 A decision point with no req SHALL set i1 <= 0, go to IDLE and increment a 4-bit stall counter; any grant SHALL clear the counter.
REQ-022 When the stall counter would reach TO_LIMIT, the next state SHALL be FAULT with timeout <= 1.
REQ-023 FAULT SHALL drive gnt0=gnt1=0 and i1=0, ignore all requests, and be left only by reset.
REQ-024 hit SHALL equal (st==HIT_STATE) delayed one cycle; each hit SHALL increment hit_cnt, saturating at 255.

Reset
REQ-025 With reset low at an edge: state <= IDLE, gnt0=gnt1=0, i1=0, hit=0, hit_cnt=0, timeout=0, stall counter=0, last-granted pointer=1.
REQ-026 Reset SHALL take priority over every other event, including a grant pending in the same cycle or FAULT.

Configuration
REQ-027 With macro BRANCH_ARBITER_HIT_STATS_EN defined, hit and hit_cnt SHALL behave per REQ-024.
REQ-028 Without BRANCH_ARBITER_HIT_STATS_EN, hit and hit_cnt SHALL be constant 0 with no counter logic; all other behaviour is unchanged.

Verification
REQ-029 Reset low 2 cycles, then st=2, req0=1, dec0=1 -> gnt0=1 the next cycle, i1=1, gnt1=0.
REQ-030 st=2 then st=5, req0=req1=1, dec0=0, dec1=1 -> gnt0 in cycle 1 with i1=0, then gnt1 in cycle 2 with i1=1.
REQ-031 req1=1 held while st=8,10,1, then st=2 -> no gnt1 until the cycle after st=2.
REQ-032 TO_LIMIT=3, st=2 for 3 cycles with no req -> timeout=1 and FAULT entered; later req0=1 at st=5 -> no grant; reset low -> timeout=0.
REQ-033 With BRANCH_ARBITER_HIT_STATS_EN defined, st=9 for 300 cycles -> hit=1 from the second cycle and hit_cnt saturates at 255; with the macro undefined -> hit=0, hit_cnt=0.
REQ-034 Reset low in the same cycle as st=2, req0=1 -> no gnt0 the following cycle, i1=0.
